// File: rtl/fifo2axi_unpack_if.sv
// -----------------------------------------------------------------------------
// fifo2axi_unpack_if
//
// Bundles the signals around the FIFO-to-AXI-stream unpacker:
//   din / din_valid / din_ready : packed memory words in from the FIFO side
//   m_tdata / m_tstrb / m_tuser / m_tlast / m_tvalid / m_tready : AXI-stream out
//   phase_err / pkt_done        : single-cycle status pulses
//
// Modports:
//   master : the unpacker itself (consumes din, drives the AXI stream)
//   slave  : the environment around it (supplies din, sinks the AXI stream)
// -----------------------------------------------------------------------------
interface fifo2axi_unpack_if #(
   parameter int TDATA_WIDTH        = 32,
   parameter int TUSER_WIDTH        = 16,
   parameter int CROPPED_DATA_WIDTH = 24
) ();

   logic [8*CROPPED_DATA_WIDTH+9:0] din;
   logic                            din_valid;
   logic                            din_ready;
   logic [8*TDATA_WIDTH-1:0]        m_tdata;
   logic [TDATA_WIDTH-1:0]          m_tstrb;
   logic [8*TUSER_WIDTH-1:0]        m_tuser;
   logic                            m_tlast;
   logic                            m_tvalid;
   logic                            m_tready;
   logic                            phase_err;
   logic                            pkt_done;

   modport master (
      input  din, din_valid, m_tready,
      output din_ready, m_tdata, m_tstrb, m_tuser, m_tlast, m_tvalid,
             phase_err, pkt_done
   );

   modport slave (
      output din, din_valid, m_tready,
      input  din_ready, m_tdata, m_tstrb, m_tuser, m_tlast, m_tvalid,
             phase_err, pkt_done
   );

endinterface

// File: rtl/fifo2axi_unpack.sv
// -----------------------------------------------------------------------------
// fifo2axi_unpack
//
// Re-packs 24-byte memory words into 32-byte AXI-stream beats. A packet is a
// header word (phase 0, carries tuser) followed by data words cycling through
// phases 1..4; four data words fill exactly three beats. Leftover bytes of a
// word are kept in a residue register and prepended to the next beat.
//
// din word layout: {payload, bcnt[9:5], phase[4:2], last[1], xtra[0]}
//   bcnt : byte count of the final beat (0 means a full beat)
//   xtra : on a last word in phase 2/3, the residue still holds data that
//          needs one more beat (flushed from the FLUSH state)
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : fifo2axi_unpack_if.master (din side, AXI-stream side, status)
// -----------------------------------------------------------------------------
module fifo2axi_unpack #(
   parameter int TDATA_WIDTH        = 32,
   parameter int TUSER_WIDTH        = 16,
   parameter int CROPPED_DATA_WIDTH = 24
) (
   input logic              clk,
   input logic              reset,
   fifo2axi_unpack_if.master bus
);

   localparam int PW = 8*CROPPED_DATA_WIDTH;  // payload bits per word
   localparam int DW = 8*TDATA_WIDTH;         // bits per output beat
   localparam int UW = 8*TUSER_WIDTH;         // tuser bits
   localparam int SW = TDATA_WIDTH;           // strobe bits
   localparam int Q  = DW - PW;               // bytes a word falls short of a beat, in bits

   localparam logic [2:0] S_HDR   = 3'd0;
   localparam logic [2:0] S_P1    = 3'd1;
   localparam logic [2:0] S_P2    = 3'd2;
   localparam logic [2:0] S_P3    = 3'd3;
   localparam logic [2:0] S_P4    = 3'd4;
   localparam logic [2:0] S_FLUSH = 3'd5;

   logic [2:0]    state, state_nxt;
   logic [PW-1:0] resid, resid_nxt;
   logic [UW-1:0] tuser_q, tuser_nxt;
   logic [4:0]    bcnt_q, bcnt_nxt;

   logic [PW-1:0] payload;
   logic [4:0]    bcnt;
   logic [2:0]    phase;
   logic          last;
   logic          xtra;

   assign payload = bus.din[PW+9:10];
   assign bcnt    = bus.din[9:5];
   assign phase   = bus.din[4:2];
   assign last    = bus.din[1];
   assign xtra    = bus.din[0];

   // The output register can take a new beat when it is empty or being drained.
   logic out_free;
   assign out_free      = !bus.m_tvalid || bus.m_tready;
   assign bus.din_ready = !reset && (state != S_FLUSH) && out_free;

   logic accept, take;
   assign accept = bus.din_valid && bus.din_ready;
   // In HDR..P4 the state code doubles as the expected din phase.
   assign take   = accept && (phase == state);

   function automatic logic [SW-1:0] strb_of(input logic [4:0] b);
      if (b == 5'd0) return {SW{1'b1}};
      return (SW'(1) << b) - SW'(1);
   endfunction

   logic          load;
   logic [DW-1:0] load_data;
   logic [SW-1:0] load_strb;
   logic          load_last;

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and infers a latch.
      state_nxt = state;
      resid_nxt = resid;
      tuser_nxt = tuser_q;
      bcnt_nxt  = bcnt_q;
      load      = 1'b0;
      load_data = '0;
      load_strb = {SW{1'b1}};
      load_last = 1'b0;

      if (take && last) bcnt_nxt = bcnt;

      case (state)
         S_HDR: begin
            if (take) begin
               tuser_nxt = payload[UW-1:0];
               state_nxt = S_P1;
            end
         end
         S_P1: begin
            if (take) begin
               resid_nxt = payload;
               if (last) begin
                  load      = 1'b1;
                  load_data = {{Q{1'b0}}, payload};
                  load_last = 1'b1;
                  load_strb = strb_of(bcnt);
                  state_nxt = S_HDR;
               end else begin
                  state_nxt = S_P2;
               end
            end
         end
         S_P2: begin
            if (take) begin
               load      = 1'b1;
               load_data = {payload[Q-1:0], resid};
               // Upper residue bits are zeroed so FLUSH can emit it unchanged.
               resid_nxt = {{Q{1'b0}}, payload[PW-1:Q]};
               if (!last) begin
                  state_nxt = S_P3;
               end else if (xtra) begin
                  state_nxt = S_FLUSH;
               end else begin
                  load_last = 1'b1;
                  load_strb = strb_of(bcnt);
                  state_nxt = S_HDR;
               end
            end
         end
         S_P3: begin
            if (take) begin
               load      = 1'b1;
               load_data = {payload[2*Q-1:0], resid[2*Q-1:0]};
               resid_nxt = {{2*Q{1'b0}}, payload[PW-1:2*Q]};
               if (!last) begin
                  state_nxt = S_P4;
               end else if (xtra) begin
                  state_nxt = S_FLUSH;
               end else begin
                  load_last = 1'b1;
                  load_strb = strb_of(bcnt);
                  state_nxt = S_HDR;
               end
            end
         end
         S_P4: begin
            if (take) begin
               load      = 1'b1;
               load_data = {payload, resid[Q-1:0]};
               if (last) begin
                  load_last = 1'b1;
                  load_strb = strb_of(bcnt);
                  state_nxt = S_HDR;
               end else begin
                  state_nxt = S_P1;
               end
            end
         end
         S_FLUSH: begin
            if (out_free) begin
               load      = 1'b1;
               load_data = {{Q{1'b0}}, resid};
               load_last = 1'b1;
               load_strb = strb_of(bcnt_q);
               state_nxt = S_HDR;
            end
         end
         default: state_nxt = S_HDR;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      if (reset) begin
         state         <= S_HDR;
         resid         <= '0;
         tuser_q       <= '0;
         bcnt_q        <= '0;
         bus.m_tdata   <= '0;
         bus.m_tstrb   <= '0;
         bus.m_tuser   <= '0;
         bus.m_tlast   <= 1'b0;
         bus.m_tvalid  <= 1'b0;
         bus.phase_err <= 1'b0;
         bus.pkt_done  <= 1'b0;
      end else begin
         state   <= state_nxt;
         resid   <= resid_nxt;
         tuser_q <= tuser_nxt;
         bcnt_q  <= bcnt_nxt;

         if (load) begin
            bus.m_tdata  <= load_data;
            bus.m_tstrb  <= load_strb;
            bus.m_tuser  <= tuser_q;
            bus.m_tlast  <= load_last;
            bus.m_tvalid <= 1'b1;
         end else if (bus.m_tready) begin
            bus.m_tvalid <= 1'b0;
         end

         bus.phase_err <= accept && (phase != state);
         bus.pkt_done  <= bus.m_tvalid && bus.m_tready && bus.m_tlast;
      end
   end

endmodule

// File: tb/tb_fifo2axi_unpack.sv
// -----------------------------------------------------------------------------
// tb_fifo2axi_unpack
//
// Scoreboard bench for fifo2axi_unpack. Each packet's expected beats are built
// from the byte stream of its data words (concatenated low word first, cut into
// 32-byte beats) and queued as the packet is driven; a monitor pops and compares
// every handshaked beat and checks the pkt_done pulse that follows a last beat.
// -----------------------------------------------------------------------------
module tb_fifo2axi_unpack;

   localparam int PW = 192;
   localparam int DW = 256;
   localparam int UW = 128;
   localparam int SW = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fifo2axi_unpack_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(16), .CROPPED_DATA_WIDTH(24)) bus ();

   fifo2axi_unpack #(.TDATA_WIDTH(32), .TUSER_WIDTH(16), .CROPPED_DATA_WIDTH(24)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   beat_t exp_q[$];
   int    n_pass     = 0;
   int    n_total    = 0;
   int    beats_seen = 0;
   int    stall_cnt  = 0;
   logic  done_exp   = 1'b0;

   // ---------------------------------------------------------------- monitor
   // Sampled on the falling edge: valid && ready here means a transfer at the
   // next rising edge.
   always @(negedge clk) begin
      beat_t e;
      if (done_exp || bus.pkt_done) begin
         n_total++;
         if (bus.pkt_done !== done_exp)
            $display("FAIL pkt_done: got %b expected %b at %0t", bus.pkt_done, done_exp, $time);
         else
            n_pass++;
      end
      done_exp = 1'b0;
      if (!reset && bus.m_tvalid && bus.m_tready) begin
         beats_seen++;
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_beat: got data=%h last=%b, expected no beat", bus.m_tdata, bus.m_tlast);
         end else begin
            e = exp_q.pop_front();
            if ({bus.m_tdata, bus.m_tstrb, bus.m_tuser, bus.m_tlast} !== {e.d, e.s, e.u, e.l})
               $display("FAIL beat%0d: got data=%h strb=%h user=%h last=%b expected data=%h strb=%h user=%h last=%b",
                        beats_seen, bus.m_tdata, bus.m_tstrb, bus.m_tuser, bus.m_tlast, e.d, e.s, e.u, e.l);
            else
               n_pass++;
         end
         done_exp = bus.m_tlast;
      end
   end

   // ---------------------------------------------------------------- helpers
   function automatic logic [PW-1:0] rand_pay();
      logic [PW-1:0] p;
      for (int i = 0; i < PW/32; i++) p[32*i +: 32] = $urandom;
      return p;
   endfunction

   // Strobe of the final beat: the low b bytes, or all bytes when b is zero.
   function automatic logic [SW-1:0] exp_strb(input int b);
      logic [SW-1:0] s;
      for (int i = 0; i < SW; i++) s[i] = (b == 0) || (i < b);
      return s;
   endfunction

   // Called and returns just after a rising edge; the word is accepted on the
   // rising edge right before return.
   task automatic send_word(input logic [PW-1:0] pay, input logic [4:0] bc,
                            input logic [2:0] ph, input logic lst, input logic xt);
      int w = 0;
      bus.din       = {pay, bc, ph, lst, xt};
      bus.din_valid = 1'b1;
      @(negedge clk);
      while (!bus.din_ready && w < 200) begin
         stall_cnt++;
         w++;
         @(negedge clk);
      end
      if (!bus.din_ready) begin
         n_total++;
         $display("FAIL din_ready_timeout: got din_ready=0 for %0d cycles expected 1", w);
      end
      @(posedge clk);
      #1;
      bus.din_valid = 1'b0;
   endtask

   task automatic send_packet(input int n, input int bc, input logic xt, input logic bad);
      logic [PW-1:0]   hdr;
      logic [PW-1:0]   words [8];
      logic [2047:0]   stream;
      int              nb;
      logic            lst;
      beat_t           e;
      stream = '0;
      hdr = rand_pay();
      for (int i = 0; i < n; i++) begin
         words[i] = rand_pay();
         stream[PW*i +: PW] = words[i];
      end
      nb = (PW*n + DW - 1) / DW;
      if (!xt && ((n % 4) == 2 || (n % 4) == 3)) nb = (PW*n) / DW;
      for (int k = 0; k < nb; k++) begin
         e.d = stream[DW*k +: DW];
         e.s = (k == nb-1) ? exp_strb(bc) : {SW{1'b1}};
         e.u = hdr[UW-1:0];
         e.l = (k == nb-1);
         exp_q.push_back(e);
      end
      send_word(hdr, 5'($urandom), 3'd0, 1'b0, 1'($urandom));
      if (bad) begin
         send_word(rand_pay(), 5'd0, 3'd2, 1'b0, 1'b0);
         n_total++;
         if (bus.phase_err !== 1'b1)
            $display("FAIL phase_err_pulse: got %b expected 1", bus.phase_err);
         else
            n_pass++;
      end
      for (int i = 0; i < n; i++) begin
         lst = (i == n-1);
         send_word(words[i], lst ? 5'(bc) : 5'($urandom), 3'((i % 4) + 1), lst,
                   lst ? xt : 1'($urandom));
         if (bad && i == 0) begin
            n_total++;
            if (bus.phase_err !== 1'b0)
               $display("FAIL phase_err_clear: got %b expected 0", bus.phase_err);
            else
               n_pass++;
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int w = 0;
      while (exp_q.size() != 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      n_total++;
      if (exp_q.size() != 0)
         $display("FAIL %s_drain: got %0d beats outstanding expected 0", name, exp_q.size());
      else
         n_pass++;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      reset         = 1'b1;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      bus.m_tready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (bus.m_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", bus.m_tvalid);
      else n_pass++;
      n_total++;
      if ({bus.m_tdata, bus.m_tstrb, bus.m_tuser, bus.m_tlast, bus.phase_err, bus.pkt_done} !== '0)
         $display("FAIL reset_outputs: got data=%h strb=%h user=%h last=%b perr=%b done=%b expected all 0",
                  bus.m_tdata, bus.m_tstrb, bus.m_tuser, bus.m_tlast, bus.phase_err, bus.pkt_done);
      else n_pass++;
      n_total++;
      if (bus.din_ready !== 1'b0) $display("FAIL reset_din_ready: got %b expected 0", bus.din_ready);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_total++;
      if (bus.din_ready !== 1'b1) $display("FAIL post_reset_din_ready: got %b expected 1", bus.din_ready);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_96b();
      send_packet(4, 0, 1'b0, 1'b0);
      wait_drain("pkt96");
   endtask

   task automatic test_20b();
      send_packet(1, 20, 1'b0, 1'b0);
      wait_drain("pkt20");
   endtask

   task automatic test_flush();
      stall_cnt = 0;
      send_packet(2, 8, 1'b1, 1'b0);
      n_total++;
      if (bus.din_ready !== 1'b0) $display("FAIL flush_din_ready: got %b expected 0", bus.din_ready);
      else n_pass++;
      send_packet(3, 3, 1'b1, 1'b0);
      send_packet(1, 7, 1'b0, 1'b0);
      wait_drain("flush");
      n_total++;
      if (stall_cnt !== 2) $display("FAIL flush_bubbles: got %0d expected 2", stall_cnt);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      stall_cnt = 0;
      send_packet(4, 0, 1'b0, 1'b0);
      send_packet(8, 13, 1'b0, 1'b0);
      send_packet(2, 0, 1'b0, 1'b0);
      send_packet(3, 31, 1'b0, 1'b0);
      send_packet(5, 1, 1'b0, 1'b0);
      wait_drain("b2b");
      n_total++;
      if (stall_cnt !== 0) $display("FAIL b2b_stalls: got %0d expected 0", stall_cnt);
      else n_pass++;
   endtask

   task automatic test_stall();
      fork
         send_packet(4, 0, 1'b0, 1'b0);
         begin
            int b0 = beats_seen;
            int w = 0;
            logic [DW+SW+UW:0] held;
            while (beats_seen == b0 && w < 100) begin
               @(negedge clk);
               w++;
            end
            @(posedge clk);
            #1;
            bus.m_tready = 1'b0;
            @(negedge clk);
            held = {bus.m_tdata, bus.m_tstrb, bus.m_tuser, bus.m_tlast};
            for (int i = 0; i < 5; i++) begin
               if (i > 0) @(negedge clk);
               n_total++;
               if ({bus.m_tdata, bus.m_tstrb, bus.m_tuser, bus.m_tlast} !== held || bus.m_tvalid !== 1'b1
                   || bus.din_ready !== 1'b0)
                  $display("FAIL stall_hold%0d: got valid=%b din_ready=%b data=%h expected valid=1 din_ready=0 data=%h",
                           i, bus.m_tvalid, bus.din_ready, bus.m_tdata, held[DW+SW+UW:SW+UW+1]);
               else
                  n_pass++;
            end
            @(posedge clk);
            #1;
            bus.m_tready = 1'b1;
         end
      join
      wait_drain("stall");
   endtask

   task automatic test_phase_err();
      send_packet(4, 0, 1'b0, 1'b1);
      wait_drain("phase_err");
   endtask

   task automatic test_reset_mid();
      bus.m_tready = 1'b0;
      send_word(rand_pay(), 5'd0, 3'd0, 1'b0, 1'b0);
      send_word(rand_pay(), 5'd0, 3'd1, 1'b0, 1'b0);
      send_word(rand_pay(), 5'd0, 3'd2, 1'b0, 1'b0);
      n_total++;
      if (bus.m_tvalid !== 1'b1) $display("FAIL mid_pending: got tvalid=%b expected 1", bus.m_tvalid);
      else n_pass++;
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== '0)
         $display("FAIL mid_reset: got tvalid=%b data=%h expected tvalid=0 data=0", bus.m_tvalid, bus.m_tdata);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_total++;
      if (bus.din_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b expected 1", bus.din_ready);
      else n_pass++;
      bus.m_tready = 1'b1;
      send_packet(4, 0, 1'b0, 1'b0);
      wait_drain("after_reset");
   endtask

   initial begin
      test_reset();
      test_96b();
      test_20b();
      test_flush();
      test_back_to_back();
      test_stall();
      test_phase_err();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
